mux_gate_sequencer: RTL and testbench

MUX_GATE_SEQUENCER -- requirements
Module: mux_gate_sequencer

---
 rtl/mux_gate_sequencer_pkg.sv | 27 ++
 rtl/mux_gate_sequencer_mux.sv | 11 +
 rtl/mux_gate_sequencer.sv | 115 +++++++++++
 tb/tb_mux_gate_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_gate_sequencer_pkg.sv
// Shared types for the mux-based gate sequencer: op codes and FSM states.
package mux_gate_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_BUF_A = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP1 = 2'd1,
    S_STEP2 = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Ops whose schedule needs the temp register and a second mux pass.
  function automatic logic is_two_step(input op_e op);
    return (op == OP_XOR) || (op == OP_XNOR) || (op == OP_NAND) || (op == OP_NOR);
  endfunction

endpackage

// File: rtl/mux_gate_sequencer_mux.sv
// Single 2:1 mux; the only evaluation element the sequencer uses on operand data.
module mux_gate_sequencer_mux (
  input  logic sel_i,
  input  logic d0_i,
  input  logic d1_i,
  output logic y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Evaluates one 2-input boolean op per request by sequencing a single shared
// 2:1 mux over one or two cycles, with a valid/ready handshake on each side.
module mux_gate_sequencer
  import mux_gate_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       up_valid,
  output logic       up_ready,
  input  logic [2:0] up_op,
  input  logic       up_a,
  input  logic       up_b,
  output logic       down_valid,
  input  logic       down_ready,
  output logic       down_o
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   a_q, a_d;
  logic   b_q, b_d;
  logic   t_q, t_d;
  logic   res_q, res_d;
  logic   mux_sel, mux_d0, mux_d1, mux_y;

  mux_gate_sequencer_mux u_mux (
    .sel_i (mux_sel),
    .d0_i  (mux_d0),
    .d1_i  (mux_d1),
    .y_o   (mux_y)
  );

  assign up_ready   = (state_q == S_IDLE) && !rst;
  assign down_valid = (state_q == S_DONE);
  assign down_o     = res_q;

  // Mux source selection: step1 schedule in STEP1, step2 schedule in STEP2.
  always_comb begin
    mux_sel = 1'b0;
    mux_d0  = 1'b0;
    mux_d1  = 1'b0;
    if (state_q == S_STEP1) begin
      case (op_q)
        OP_AND, OP_NAND: begin mux_sel = a_q; mux_d1 = b_q;  mux_d0 = 1'b0; end
        OP_OR,  OP_NOR:  begin mux_sel = a_q; mux_d1 = 1'b1; mux_d0 = b_q;  end
        OP_XOR, OP_XNOR: begin mux_sel = b_q; mux_d1 = 1'b0; mux_d0 = 1'b1; end
        OP_NOT_A:        begin mux_sel = a_q; mux_d1 = 1'b0; mux_d0 = 1'b1; end
        OP_BUF_A:        begin mux_sel = a_q; mux_d1 = 1'b1; mux_d0 = 1'b0; end
        default:         begin mux_sel = 1'b0; mux_d1 = 1'b0; mux_d0 = 1'b0; end
      endcase
    end else if (state_q == S_STEP2) begin
      case (op_q)
        OP_XOR:         begin mux_sel = a_q; mux_d1 = t_q;  mux_d0 = b_q;  end
        OP_XNOR:        begin mux_sel = a_q; mux_d1 = b_q;  mux_d0 = t_q;  end
        OP_NAND, OP_NOR: begin mux_sel = t_q; mux_d1 = 1'b0; mux_d0 = 1'b1; end
        default:        begin mux_sel = 1'b0; mux_d1 = 1'b0; mux_d0 = 1'b0; end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (up_valid && up_ready) begin
          op_d    = op_e'(up_op);
          a_d     = up_a;
          b_d     = up_b;
          state_d = S_STEP1;
        end
      end
      S_STEP1: begin
        if (is_two_step(op_q)) begin
          t_d     = mux_y;
          state_d = S_STEP2;
        end else begin
          res_d   = mux_y;
          state_d = S_DONE;
        end
      end
      S_STEP2: begin
        res_d   = mux_y;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (down_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_AND;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      t_q     <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Directed self-checking bench for mux_gate_sequencer.
module tb_mux_gate_sequencer;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [2:0] up_op;
  logic       up_a;
  logic       up_b;
  logic       down_valid;
  logic       down_ready;
  logic       down_o;

  int errors = 0;
  int checks = 0;

  mux_gate_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_op      (up_op),
    .up_a       (up_a),
    .up_b       (up_b),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_o     (down_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gold(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (down_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (down_valid) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_valid = 1'b0; up_op = '0; up_a = 1'b0; up_b = 1'b0; down_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL reset_up_ready: got %b want 0", up_ready); end
    checks++;
    if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid: got %b want 0", down_valid); end
    checks++;
    if (down_o !== 1'b0) begin errors++; $display("FAIL reset_down_o: got %b want 0", down_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_release_up_ready: got %b want 1", up_ready); end
  endtask

  task automatic test_exhaustive();
    bit   ok;
    logic exp;
    down_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      for (int v = 0; v < 4; v++) begin
        up_op = o[2:0]; up_a = v[1]; up_b = v[0]; up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        wait_dv(ok);
        exp = gold(o[2:0], v[1], v[0]);
        checks++;
        if (!ok) begin
          errors++; $display("FAIL exh_timeout op=%0d a=%b b=%b: down_valid never rose", o, v[1], v[0]);
        end else if (down_o !== exp) begin
          errors++; $display("FAIL exh op=%0d a=%b b=%b: got %b want %b", o, v[1], v[0], down_o, exp);
        end
        tick();
      end
    end
  endtask

  task automatic test_latency();
    down_ready = 1'b0;
    // AND 1,1: handshake completes at edge 1, result visible after edge 2
    up_op = 3'd0; up_a = 1'b1; up_b = 1'b1; up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    checks++;
    if (down_valid !== 1'b0) begin errors++; $display("FAIL lat_and_e1: down_valid got %b want 0", down_valid); end
    tick();
    checks++;
    if (down_valid !== 1'b1 || down_o !== 1'b1) begin
      errors++; $display("FAIL lat_and_e2: valid/o got %b/%b want 1/1", down_valid, down_o);
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    // XOR 1,1: two-step, result visible after edge 3
    up_op = 3'd2; up_a = 1'b1; up_b = 1'b1; up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    tick();
    checks++;
    if (down_valid !== 1'b0) begin errors++; $display("FAIL lat_xor_e2: down_valid got %b want 0", down_valid); end
    tick();
    checks++;
    if (down_valid !== 1'b1 || down_o !== 1'b0) begin
      errors++; $display("FAIL lat_xor_e3: valid/o got %b/%b want 1/0", down_valid, down_o);
    end
    down_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    down_ready = 1'b0;
    up_op = 3'd4; up_a = 1'b0; up_b = 1'b0; up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: down_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (down_valid !== 1'b1 || down_o !== 1'b1 || up_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: valid/o/up_ready got %b/%b/%b want 1/1/0", i, down_valid, down_o, up_ready);
      end
      tick();
    end
    down_ready = 1'b1;
    tick();
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid/up_ready got %b/%b want 0/1", down_valid, up_ready);
    end
  endtask

  task automatic test_input_change();
    bit ok;
    down_ready = 1'b1;
    up_op = 3'd5; up_a = 1'b0; up_b = 1'b0; up_valid = 1'b1;
    tick();
    up_valid = 1'b0; up_op = 3'd0; up_a = 1'b1; up_b = 1'b1;
    wait_dv(ok);
    checks++;
    if (!ok || down_o !== 1'b1) begin
      errors++; $display("FAIL inchg_xnor: valid/o got %b/%b want 1/1", down_valid, down_o);
    end
    tick();
    // XOR 0,0 then a->1: a late change would yield 1, captured operands yield 0
    up_op = 3'd2; up_a = 1'b0; up_b = 1'b0; up_valid = 1'b1;
    tick();
    up_valid = 1'b0; up_a = 1'b1;
    wait_dv(ok);
    checks++;
    if (!ok || down_o !== 1'b0) begin
      errors++; $display("FAIL inchg_xor: valid/o got %b/%b want 1/0", down_valid, down_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    down_ready = 1'b1;
    up_op = 3'd2; up_a = 1'b1; up_b = 1'b0; up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (down_valid !== 1'b0 || down_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: valid/o got %b/%b want 0/0", down_valid, down_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (up_ready !== 1'b1) begin errors++; $display("FAIL rstmid_up_ready: got %b want 1", up_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (down_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_result cyc%0d: got %b want 0", i, down_valid); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    down_ready = 1'b0;
    up_op = 3'd0; up_a = 1'b1; up_b = 1'b1; up_valid = 1'b1;
    tick();
    up_op = 3'd1; up_a = 1'b0; up_b = 1'b0;
    wait_dv(ok);
    tick();
    checks++;
    if (!ok || down_valid !== 1'b1 || down_o !== 1'b1 || up_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: valid/o/up_ready got %b/%b/%b want 1/1/0", down_valid, down_o, up_ready);
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_no_overlap: valid/up_ready got %b/%b want 0/1", down_valid, up_ready);
    end
    tick();
    up_valid = 1'b0;
    checks++;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: up_ready got %b want 0", up_ready); end
    wait_dv(ok);
    checks++;
    if (!ok || down_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second: valid/o got %b/%b want 1/0", down_valid, down_o);
    end
    down_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_latency();
    test_backpressure();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
